// File: rtl/fw_cmd_decoder.sv
// ---------------------------------------------------------------------------
// fw_cmd_decoder
//
// Decodes 32-bit firmware command words addressed to this device and turns
// them into held configuration registers, one-cycle strobes and a sticky
// status word. An execute command with a one-hot test number starts a test
// run; the decoder stays busy (cmd_ready low) until the matching test_done
// bit arrives.
//
// Command word: [31:28] device_id, [27:24] op_code, [23:0] body.
//
// Optional feature (macro FW_CMD_DECODER_TIMEOUT_EN):
//   A 16-bit watchdog counts cycles spent running a test. If it reaches
//   16'hFFFF with no matching test_done, status bit 31 is set and the
//   decoder returns to idle.
//
// Ports:
//   fw_axi_clk        in   clock, rising edge
//   fw_rst            in   synchronous active-high reset
//   cmd_word[31:0]    in   command word
//   cmd_valid         in   command present (taken when cmd_valid & cmd_ready)
//   cmd_ready         out  decoder idle, able to take a command
//   test_done[3:0]    in   one-cycle done pulse, bit i for test number 2^i
//   cfg_static_0_reg  out  held body of W_CFG_STATIC_0
//   cfg_static_1_reg  out  held body of W_CFG_STATIC_1
//   execute_cfg_reg   out  held body of W_EXECUTE
//   array_wr          out  one-cycle array write strobe
//   array_sel[1:0]    out  array index 0/1/2 for array_wr
//   array_wdata[23:0] out  array write data
//   read_req          out  one-cycle read strobe
//   read_op[3:0]      out  op_code of the read
//   execute_start     out  one-cycle pulse when a test run begins
//   rst_fw_pulse      out  one-cycle pulse on W_RST_FW
//   status_reg[31:0]  out  sticky status bits (18..30 always zero)
// ---------------------------------------------------------------------------
module fw_cmd_decoder #(
  parameter logic [3:0] FIRMWARE_ID = 4'h1
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst,
  input  logic [31:0] cmd_word,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  test_done,
  output logic [23:0] cfg_static_0_reg,
  output logic [23:0] cfg_static_1_reg,
  output logic [23:0] execute_cfg_reg,
  output logic        array_wr,
  output logic [1:0]  array_sel,
  output logic [23:0] array_wdata,
  output logic        read_req,
  output logic [3:0]  read_op,
  output logic        execute_start,
  output logic        rst_fw_pulse,
  output logic [31:0] status_reg
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP              = 4'h0,
    OP_W_RST_FW          = 4'h1,
    OP_W_CFG_STATIC_0    = 4'h2,
    OP_R_CFG_STATIC_0    = 4'h3,
    OP_W_CFG_STATIC_1    = 4'h4,
    OP_R_CFG_STATIC_1    = 4'h5,
    OP_W_CFG_ARRAY_0     = 4'h6,
    OP_R_CFG_ARRAY_0     = 4'h7,
    OP_W_CFG_ARRAY_1     = 4'h8,
    OP_R_CFG_ARRAY_1     = 4'h9,
    OP_W_CFG_ARRAY_2     = 4'hA,
    OP_R_CFG_ARRAY_2     = 4'hB,
    OP_R_STATUS          = 4'hC,
    OP_R_EXECUTE_CFG     = 4'hD,
    OP_W_STATUS_FW_CLEAR = 4'hE,
    OP_W_EXECUTE         = 4'hF
  } op_t;

  state_t      r_state;
  logic        r_cmd_ready;
  logic [23:0] r_cfg_static_0;
  logic [23:0] r_cfg_static_1;
  logic [23:0] r_execute_cfg;
  logic        r_array_wr;
  logic [1:0]  r_array_sel;
  logic [23:0] r_array_wdata;
  logic        r_read_req;
  logic [3:0]  r_read_op;
  logic        r_execute_start;
  logic        r_rst_fw_pulse;
  logic [31:0] r_status;
  logic [1:0]  r_test_idx;
`ifdef FW_CMD_DECODER_TIMEOUT_EN
  logic [15:0] r_wd_cnt;
`endif

  op_t         w_op;
  logic [23:0] w_body;
  logic        w_hit;
  logic [3:0]  w_test_num;
  logic        w_test_ok;
  logic [1:0]  w_test_idx;
  logic        w_done_hit;
  logic [4:0]  w_done_bit;

  assign w_op   = op_t'(cmd_word[27:24]);
  assign w_body = cmd_word[23:0];
  // A command counts only when handshaken and addressed to this device.
  assign w_hit  = cmd_valid && r_cmd_ready && (cmd_word[31:28] == FIRMWARE_ID);

  // Test number must be one-hot; its bit position indexes test_done and
  // selects the completion status bit 14+i.
  assign w_test_num = cmd_word[15:12];
  always_comb begin
    w_test_ok  = 1'b1;
    w_test_idx = 2'd0;
    case (w_test_num)
      4'b0001: w_test_idx = 2'd0;
      4'b0010: w_test_idx = 2'd1;
      4'b0100: w_test_idx = 2'd2;
      4'b1000: w_test_idx = 2'd3;
      default: w_test_ok  = 1'b0;
    endcase
  end

  assign w_done_hit = test_done[r_test_idx];
  assign w_done_bit = 5'd14 + {3'b000, r_test_idx};

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge fw_axi_clk) begin
    if (fw_rst) begin
      r_state         <= ST_IDLE;
      r_cmd_ready     <= 1'b1;
      r_cfg_static_0  <= '0;
      r_cfg_static_1  <= '0;
      r_execute_cfg   <= '0;
      r_array_wr      <= 1'b0;
      r_array_sel     <= '0;
      r_array_wdata   <= '0;
      r_read_req      <= 1'b0;
      r_read_op       <= '0;
      r_execute_start <= 1'b0;
      r_rst_fw_pulse  <= 1'b0;
      r_status        <= '0;
      r_test_idx      <= '0;
`ifdef FW_CMD_DECODER_TIMEOUT_EN
      r_wd_cnt        <= '0;
`endif
    end else begin
      // NOTE: strobes default low every cycle so each one lasts exactly one
      // clock; only the command that raises it overrides the default.
      r_array_wr      <= 1'b0;
      r_read_req      <= 1'b0;
      r_execute_start <= 1'b0;
      r_rst_fw_pulse  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            case (w_op)
              OP_W_RST_FW: begin
                r_cfg_static_0 <= '0;
                r_cfg_static_1 <= '0;
                r_execute_cfg  <= '0;
                r_status       <= 32'h0000_0001;
                r_rst_fw_pulse <= 1'b1;
              end
              OP_W_CFG_STATIC_0: begin
                r_cfg_static_0 <= w_body;
                r_status[1]    <= 1'b1;
              end
              OP_W_CFG_STATIC_1: begin
                r_cfg_static_1 <= w_body;
                r_status[3]    <= 1'b1;
              end
              OP_W_CFG_ARRAY_0: begin
                r_array_wr    <= 1'b1;
                r_array_sel   <= 2'd0;
                r_array_wdata <= w_body;
                r_status[5]   <= 1'b1;
              end
              OP_W_CFG_ARRAY_1: begin
                r_array_wr    <= 1'b1;
                r_array_sel   <= 2'd1;
                r_array_wdata <= w_body;
                r_status[7]   <= 1'b1;
              end
              OP_W_CFG_ARRAY_2: begin
                r_array_wr    <= 1'b1;
                r_array_sel   <= 2'd2;
                r_array_wdata <= w_body;
                r_status[9]   <= 1'b1;
              end
              OP_R_CFG_STATIC_0: begin
                r_read_req  <= 1'b1;
                r_read_op   <= cmd_word[27:24];
                r_status[2] <= 1'b1;
              end
              OP_R_CFG_STATIC_1: begin
                r_read_req  <= 1'b1;
                r_read_op   <= cmd_word[27:24];
                r_status[4] <= 1'b1;
              end
              OP_R_CFG_ARRAY_0: begin
                r_read_req  <= 1'b1;
                r_read_op   <= cmd_word[27:24];
                r_status[6] <= 1'b1;
              end
              OP_R_CFG_ARRAY_1: begin
                r_read_req  <= 1'b1;
                r_read_op   <= cmd_word[27:24];
                r_status[8] <= 1'b1;
              end
              OP_R_CFG_ARRAY_2: begin
                r_read_req   <= 1'b1;
                r_read_op    <= cmd_word[27:24];
                r_status[10] <= 1'b1;
              end
              OP_R_STATUS: begin
                r_read_req   <= 1'b1;
                r_read_op    <= cmd_word[27:24];
                r_status[11] <= 1'b1;
              end
              OP_R_EXECUTE_CFG: begin
                r_read_req   <= 1'b1;
                r_read_op    <= cmd_word[27:24];
                r_status[12] <= 1'b1;
              end
              OP_W_STATUS_FW_CLEAR: begin
                r_status <= '0;
              end
              OP_W_EXECUTE: begin
                r_execute_cfg <= w_body;
                r_status[13]  <= 1'b1;
                if (w_test_ok) begin
                  r_state         <= ST_RUN;
                  r_cmd_ready     <= 1'b0;
                  r_execute_start <= 1'b1;
                  r_test_idx      <= w_test_idx;
`ifdef FW_CMD_DECODER_TIMEOUT_EN
                  r_wd_cnt        <= '0;
`endif
                end else begin
                  // Malformed test number: flag it and stay idle.
                  r_status[31] <= 1'b1;
                end
              end
              default: ; // OP_NOOP
            endcase
          end
        end

        ST_RUN: begin
          // Only the done bit of the running test ends the run; a matching
          // done takes priority over a watchdog expiry in the same cycle.
          if (w_done_hit) begin
            r_state              <= ST_IDLE;
            r_cmd_ready          <= 1'b1;
            r_status[w_done_bit] <= 1'b1;
          end
`ifdef FW_CMD_DECODER_TIMEOUT_EN
          else if (r_wd_cnt == 16'hFFFF) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_status[31] <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
          end
`endif
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready        = r_cmd_ready;
  assign cfg_static_0_reg = r_cfg_static_0;
  assign cfg_static_1_reg = r_cfg_static_1;
  assign execute_cfg_reg  = r_execute_cfg;
  assign array_wr         = r_array_wr;
  assign array_sel        = r_array_sel;
  assign array_wdata      = r_array_wdata;
  assign read_req         = r_read_req;
  assign read_op          = r_read_op;
  assign execute_start    = r_execute_start;
  assign rst_fw_pulse     = r_rst_fw_pulse;
  assign status_reg       = r_status;

endmodule

// File: tb/tb_fw_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_fw_cmd_decoder
//
// Directed scenarios for the documented command examples, reset behaviour
// and test-run handshake, followed by a randomized run compared cycle by
// cycle against a behavioural model of the command rules. The watchdog
// scenario is compiled in when FW_CMD_DECODER_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_fw_cmd_decoder;

  localparam logic [3:0] FW_ID = 4'h1;

  logic        clk;
  logic        fw_rst;
  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  test_done;
  logic [23:0] cfg_static_0_reg;
  logic [23:0] cfg_static_1_reg;
  logic [23:0] execute_cfg_reg;
  logic        array_wr;
  logic [1:0]  array_sel;
  logic [23:0] array_wdata;
  logic        read_req;
  logic [3:0]  read_op;
  logic        execute_start;
  logic        rst_fw_pulse;
  logic [31:0] status_reg;

  int n_total = 0;
  int n_bad   = 0;

  fw_cmd_decoder #(.FIRMWARE_ID(FW_ID)) dut (
    .fw_axi_clk       (clk),
    .fw_rst           (fw_rst),
    .cmd_word         (cmd_word),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .test_done        (test_done),
    .cfg_static_0_reg (cfg_static_0_reg),
    .cfg_static_1_reg (cfg_static_1_reg),
    .execute_cfg_reg  (execute_cfg_reg),
    .array_wr         (array_wr),
    .array_sel        (array_sel),
    .array_wdata      (array_wdata),
    .read_req         (read_req),
    .read_op          (read_op),
    .execute_start    (execute_start),
    .rst_fw_pulse     (rst_fw_pulse),
    .status_reg       (status_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic v, input logic [3:0] d);
    cmd_word  = w;
    cmd_valid = v;
    test_done = d;
  endtask

  task automatic do_reset();
    drive(32'h0, 1'b0, 4'h0);
    fw_rst = 1'b1;
    tick();
    tick();
    fw_rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_total++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    n_total++; if (status_reg !== 32'h0) begin n_bad++; $display("FAIL reset_status got=%h exp=0", status_reg); end
    n_total++; if ({cfg_static_0_reg, cfg_static_1_reg, execute_cfg_reg} !== 72'h0) begin
      n_bad++; $display("FAIL reset_cfg got=%h/%h/%h exp=0", cfg_static_0_reg, cfg_static_1_reg, execute_cfg_reg); end
    n_total++; if ({array_wr, read_req, execute_start, rst_fw_pulse} !== 4'b0) begin
      n_bad++; $display("FAIL reset_pulses got=%b exp=0000", {array_wr, read_req, execute_start, rst_fw_pulse}); end
    n_total++; if ({array_sel, array_wdata, read_op} !== 30'h0) begin
      n_bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", array_sel, array_wdata, read_op); end
  endtask

  // Load of cfg_static_0, then a command for another device is ignored.
  task automatic test_cfg_and_mismatch();
    do_reset();
    drive(32'h1200_0ABC, 1'b1, 4'h0);
    tick();
    drive(32'h2200_0ABC, 1'b1, 4'h0);
    n_total++; if (cfg_static_0_reg !== 24'h000ABC) begin n_bad++; $display("FAIL cfg0_load got=%h exp=000abc", cfg_static_0_reg); end
    n_total++; if (status_reg !== 32'h2) begin n_bad++; $display("FAIL cfg0_status got=%h exp=2", status_reg); end
    tick();
    drive(32'h0, 1'b0, 4'h0);
    n_total++; if (cfg_static_0_reg !== 24'h000ABC || status_reg !== 32'h2) begin
      n_bad++; $display("FAIL mismatch_ignored got=%h/%h exp=000abc/2", cfg_static_0_reg, status_reg); end
    n_total++; if ({array_wr, read_req, execute_start, rst_fw_pulse, cmd_ready} !== 5'b00001) begin
      n_bad++; $display("FAIL mismatch_pulses got=%b exp=00001", {array_wr, read_req, execute_start, rst_fw_pulse, cmd_ready}); end
  endtask

  // Valid execute of test 2, wrong done ignored, command in RUN refused.
  task automatic test_execute();
    do_reset();
    drive(32'h1F00_2000, 1'b1, 4'h0);
    tick();
    n_total++; if (execute_start !== 1'b1 || cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL exec_start got start=%b ready=%b exp=1/0", execute_start, cmd_ready); end
    n_total++; if (execute_cfg_reg !== 24'h002000 || status_reg !== 32'h2000) begin
      n_bad++; $display("FAIL exec_cfg got=%h/%h exp=002000/2000", execute_cfg_reg, status_reg); end
    drive(32'h1200_0111, 1'b1, 4'b0001);
    tick();
    n_total++; if (execute_start !== 1'b0 || cmd_ready !== 1'b0 || status_reg !== 32'h2000) begin
      n_bad++; $display("FAIL exec_wrong_done got start=%b ready=%b status=%h exp=0/0/2000", execute_start, cmd_ready, status_reg); end
    n_total++; if (cfg_static_0_reg !== 24'h0) begin n_bad++; $display("FAIL run_cmd_refused got=%h exp=0", cfg_static_0_reg); end
    drive(32'h0, 1'b0, 4'b0010);
    tick();
    drive(32'h0, 1'b0, 4'h0);
    n_total++; if (cmd_ready !== 1'b1 || status_reg !== 32'h0000_A000) begin
      n_bad++; $display("FAIL exec_done got ready=%b status=%h exp=1/0000a000", cmd_ready, status_reg); end
  endtask

  task automatic test_bad_execute();
    do_reset();
    drive(32'h1F00_3000, 1'b1, 4'h0);
    tick();
    drive(32'h0, 1'b0, 4'h0);
    n_total++; if (execute_start !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL bad_exec got start=%b ready=%b exp=0/1", execute_start, cmd_ready); end
    n_total++; if (status_reg !== 32'h8000_2000 || execute_cfg_reg !== 24'h003000) begin
      n_bad++; $display("FAIL bad_exec_status got=%h/%h exp=80002000/003000", status_reg, execute_cfg_reg); end
  endtask

  // Array write 2, then status clear; test_done in IDLE changes nothing.
  task automatic test_array_clear();
    do_reset();
    drive(32'h1A00_0055, 1'b1, 4'h0);
    tick();
    n_total++; if (array_wr !== 1'b1 || array_sel !== 2'd2 || array_wdata !== 24'h55) begin
      n_bad++; $display("FAIL array_wr got=%b/%0d/%h exp=1/2/000055", array_wr, array_sel, array_wdata); end
    n_total++; if (status_reg !== 32'h200) begin n_bad++; $display("FAIL array_status got=%h exp=200", status_reg); end
    drive(32'h1E00_0000, 1'b1, 4'h0);
    tick();
    n_total++; if (array_wr !== 1'b0 || status_reg !== 32'h0) begin
      n_bad++; $display("FAIL clear got wr=%b status=%h exp=0/0", array_wr, status_reg); end
    drive(32'h0, 1'b0, 4'hF);
    tick();
    drive(32'h0, 1'b0, 4'h0);
    n_total++; if (status_reg !== 32'h0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_done_ignored got=%h/%b exp=0/1", status_reg, cmd_ready); end
  endtask

  // Read strobe, then W_RST_FW wipes configuration and status.
  task automatic test_read_and_rst_fw();
    do_reset();
    drive(32'h1400_0777, 1'b1, 4'h0);
    tick();
    drive(32'h1C00_0000, 1'b1, 4'h0);
    tick();
    n_total++; if (read_req !== 1'b1 || read_op !== 4'hC || status_reg !== 32'h808) begin
      n_bad++; $display("FAIL read got=%b/%h/%h exp=1/c/808", read_req, read_op, status_reg); end
    drive(32'h1100_0000, 1'b1, 4'h0);
    tick();
    drive(32'h0, 1'b0, 4'h0);
    n_total++; if (rst_fw_pulse !== 1'b1 || status_reg !== 32'h1 || cfg_static_1_reg !== 24'h0 || read_req !== 1'b0) begin
      n_bad++; $display("FAIL rst_fw got=%b/%h/%h/%b exp=1/1/0/0", rst_fw_pulse, status_reg, cfg_static_1_reg, read_req); end
    tick();
    n_total++; if (rst_fw_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_fw_one_cycle got=%b exp=0", rst_fw_pulse); end
  endtask

  // fw_rst during a run aborts it; a later done must not set any bit.
  task automatic test_reset_in_run();
    do_reset();
    drive(32'h1F00_4000, 1'b1, 4'h0);
    tick();
    drive(32'h0, 1'b0, 4'h0);
    tick();
    fw_rst = 1'b1;
    tick();
    fw_rst = 1'b0;
    drive(32'h0, 1'b0, 4'b0100);
    tick();
    drive(32'h0, 1'b0, 4'h0);
    n_total++; if (status_reg !== 32'h0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_run got=%h/%b exp=0/1", status_reg, cmd_ready); end
  endtask

`ifdef FW_CMD_DECODER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    drive(32'h1F00_1000, 1'b1, 4'h0);
    tick();
    drive(32'h0, 1'b0, 4'h0);
    for (int i = 0; i < 65535; i++) tick();
    n_total++; if (cmd_ready !== 1'b0 || status_reg !== 32'h2000) begin
      n_bad++; $display("FAIL wd_early got=%b/%h exp=0/2000", cmd_ready, status_reg); end
    tick();
    n_total++; if (cmd_ready !== 1'b1 || status_reg !== 32'h8000_2000) begin
      n_bad++; $display("FAIL wd_expire got=%b/%h exp=1/80002000", cmd_ready, status_reg); end
  endtask
`endif

  // -------------------------------------------------------------------------
  // Behavioural model: command effects described as rules on op_code value.
  logic [23:0] m_cfg0, m_cfg1, m_exec, m_wdata;
  logic [31:0] m_status;
  logic [1:0]  m_sel;
  logic [3:0]  m_rop;
  logic        m_busy;
  int          m_test;
  logic        e_wr, e_rd, e_start, e_rstp;

  function automatic bit is_read_op(input int op);
    return op == 3 || op == 5 || op == 7 || op == 9 || op == 11 || op == 12 || op == 13;
  endfunction

  task automatic model_step(input logic [31:0] w, input logic v, input logic [3:0] d);
    int op, tn;
    logic [23:0] body;
    e_wr = 0; e_rd = 0; e_start = 0; e_rstp = 0;
    op   = int'(w[27:24]);
    body = w[23:0];
    if (m_busy) begin
      if (d[m_test]) begin
        m_busy = 0;
        m_status[14 + m_test] = 1'b1;
      end
    end else if (v && w[31:28] == FW_ID) begin
      if (op == 1) begin
        m_cfg0 = 0; m_cfg1 = 0; m_exec = 0; m_status = 32'h1; e_rstp = 1;
      end else if (op == 2) begin
        m_cfg0 = body; m_status[1] = 1'b1;
      end else if (op == 4) begin
        m_cfg1 = body; m_status[3] = 1'b1;
      end else if (op == 6 || op == 8 || op == 10) begin
        e_wr = 1; m_sel = 2'((op - 6) / 2); m_wdata = body; m_status[op - 1] = 1'b1;
      end else if (is_read_op(op)) begin
        e_rd = 1; m_rop = 4'(op); m_status[op - 1] = 1'b1;
      end else if (op == 14) begin
        m_status = 0;
      end else if (op == 15) begin
        m_exec = body; m_status[13] = 1'b1;
        tn = int'(body[15:12]);
        if (tn == 1 || tn == 2 || tn == 4 || tn == 8) begin
          m_busy = 1; m_test = $clog2(tn); e_start = 1;
        end else begin
          m_status[31] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic        v;
    logic [3:0]  d;
    do_reset();
    m_cfg0 = 0; m_cfg1 = 0; m_exec = 0; m_wdata = 0; m_status = 0;
    m_sel = 0; m_rop = 0; m_busy = 0; m_test = 0;
    for (int c = 0; c < 3000; c++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 8) w[31:28] = FW_ID;
      if (w[27:24] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'(1 << $urandom_range(0, 3));
      if (w[27:24] == 4'h1 && $urandom_range(0, 3) != 0) w[27:24] = 4'h2;
      v = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      drive(w, v, d);
      model_step(w, v, d);
      tick();
      n_total++; if (cmd_ready !== !m_busy) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, cmd_ready, !m_busy); end
      n_total++; if (status_reg !== m_status) begin n_bad++; $display("FAIL rnd_status c=%0d got=%h exp=%h", c, status_reg, m_status); end
      n_total++; if ({cfg_static_0_reg, cfg_static_1_reg, execute_cfg_reg} !== {m_cfg0, m_cfg1, m_exec}) begin
        n_bad++; $display("FAIL rnd_cfg c=%0d got=%h/%h/%h exp=%h/%h/%h", c, cfg_static_0_reg, cfg_static_1_reg, execute_cfg_reg, m_cfg0, m_cfg1, m_exec); end
      n_total++; if ({array_wr, read_req, execute_start, rst_fw_pulse} !== {e_wr, e_rd, e_start, e_rstp}) begin
        n_bad++; $display("FAIL rnd_pulses c=%0d got=%b exp=%b", c, {array_wr, read_req, execute_start, rst_fw_pulse}, {e_wr, e_rd, e_start, e_rstp}); end
      n_total++; if ({array_sel, array_wdata, read_op} !== {m_sel, m_wdata, m_rop}) begin
        n_bad++; $display("FAIL rnd_data c=%0d got=%h/%h/%h exp=%h/%h/%h", c, array_sel, array_wdata, read_op, m_sel, m_wdata, m_rop); end
    end
    drive(32'h0, 1'b0, 4'h0);
  endtask

  initial begin
    fw_rst = 1'b1;
    drive(32'h0, 1'b0, 4'h0);
    test_reset();
    test_cfg_and_mismatch();
    test_execute();
    test_bad_execute();
    test_array_clear();
    test_read_and_rst_fw();
    test_reset_in_run();
`ifdef FW_CMD_DECODER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
